// File: rtl/chase_scan_ctrl_pkg.sv
// Shared types and constants for the chase/scan display controller.
// Holds the FSM states, the digit-enable codes, the mode codes and small step helpers.
package chase_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] AM_D0  = 4'b1110;
    localparam logic [3:0] AM_D1  = 4'b1101;
    localparam logic [3:0] AM_D2  = 4'b1011;
    localparam logic [3:0] AM_D3  = 4'b0111;
    localparam logic [3:0] AM_OFF = 4'b1111;

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    function automatic logic [3:0] digit_enable(input logic [1:0] d);
        case (d)
            2'd0:    return AM_D0;
            2'd1:    return AM_D1;
            2'd2:    return AM_D2;
            default: return AM_D3;
        endcase
    endfunction

    // The chase has seven positions, so both directions wrap at 6.
    function automatic logic [2:0] step_move(input logic [2:0] s, input logic down);
        if (down) return (s == 3'd0) ? 3'd6 : s - 3'd1;
        else      return (s >= 3'd6) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/chase_pattern_rom.sv
// Combinational segment pattern for one digit, from mode, digit index and chase step.
// Segment k = (step + offset) mod 7 maps to bit 7-k; bit 0 is never lit.
module chase_pattern_rom
    import chase_scan_ctrl_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [1:0] d,
    input  logic [2:0] step,
    output logic [7:0] pattern
);

    logic [3:0] sum;
    logic [2:0] k;
    logic [7:0] lit;

    always_comb begin
        sum = {1'b0, step} + ((mode == MODE_ROTATE) ? {2'b00, d} : 4'd0);
        k   = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
        lit = 8'h80 >> k;
        case (mode)
            MODE_CHASE, MODE_ROTATE: pattern = ~lit;
            MODE_INVERT:             pattern = lit | 8'h01;
            default:                 pattern = 8'hFF;
        endcase
    end

endmodule

// File: rtl/chase_scan_ctrl.sv
// Four-digit multiplexed LED chase controller: scan divider with blanking,
// chase step divider, IDLE/RUN/PAUSE FSM and registered digit/segment drive.
module chase_scan_ctrl
    import chase_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int STEP_DIV  = 12500000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       re,
    input  logic       run,
    input  logic       dir,
    input  logic       step_req,
    input  logic       clear,
    input  logic [1:0] mode,
    output logic [3:0] am,
    output logic [7:0] out,
    output logic [2:0] step,
    output logic       running
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    state_e            state_q, state_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [STEP_W-1:0] sdiv_q, sdiv_d;
    logic [1:0]        d_q, d_d;
    logic [1:0]        mode_q, mode_d;
    logic [2:0]        step_q, step_d;
    logic              req_q;
    logic [3:0]        am_q, am_d;
    logic [7:0]        out_q, out_d;
    logic              running_q;
    logic              scan_tick, step_tick, req_rise;
    logic [7:0]        pat;

    chase_pattern_rom u_rom (
        .mode    (mode_d),
        .d       (d_d),
        .step    (step_d),
        .pattern (pat)
    );

    always_comb begin
        scan_tick = (state_q != ST_IDLE) && (scan_q == SCAN_W'(SCAN_DIV - 1));
        step_tick = (state_q == ST_RUN) && (sdiv_q == STEP_W'(STEP_DIV - 1));
        req_rise  = step_req && !req_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run)  state_d = ST_RUN;
            ST_RUN:   if (!run) state_d = ST_PAUSE;
            ST_PAUSE: if (run)  state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        scan_d = (state_q == ST_IDLE || scan_tick) ? '0 : scan_q + 1'b1;
        d_d    = scan_tick ? d_q + 2'd1 : d_q;
        // Mode only changes at slot boundaries so a digit never shows two patterns.
        mode_d = (state_q == ST_IDLE || scan_tick) ? mode : mode_q;

        sdiv_d = sdiv_q;
        if (state_q == ST_IDLE || clear) sdiv_d = '0;
        else if (state_q == ST_RUN)      sdiv_d = step_tick ? '0 : sdiv_q + 1'b1;

        step_d = step_q;
        if (clear)
            step_d = 3'd0;
        else if (step_tick || (state_q == ST_PAUSE && req_rise))
            step_d = step_move(step_q, dir);

        am_d = AM_OFF;
        if (state_d != ST_IDLE && scan_d >= SCAN_W'(BLANK_CYC))
            am_d = digit_enable(d_d);

        // Segments load with the enable, and hold while the digits are blanked.
        out_d = out_q;
        if (state_d == ST_IDLE)  out_d = 8'hFF;
        else if (am_d != AM_OFF) out_d = pat;
    end

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            state_q   <= ST_IDLE;
            scan_q    <= '0;
            sdiv_q    <= '0;
            d_q       <= 2'd0;
            mode_q    <= MODE_CHASE;
            step_q    <= 3'd0;
            req_q     <= 1'b0;
            am_q      <= AM_OFF;
            out_q     <= 8'hFF;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            sdiv_q    <= sdiv_d;
            d_q       <= d_d;
            mode_q    <= mode_d;
            step_q    <= step_d;
            req_q     <= step_req;
            am_q      <= am_d;
            out_q     <= out_d;
            running_q <= (state_q == ST_RUN);
        end
    end

    assign am      = am_q;
    assign out     = out_q;
    assign step    = step_q;
    assign running = running_q;

endmodule

// File: tb/tb_chase_scan_ctrl.sv
// Directed and randomized bench for chase_scan_ctrl against a cycle-level reference model.
module tb_chase_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int STEP_DIV  = 64;
    localparam int BLANK_CYC = 2;

    logic       clk;
    logic       re;
    logic       run;
    logic       dir;
    logic       step_req;
    logic       clear;
    logic [1:0] mode;
    logic [3:0] am_w;
    logic [7:0] out_w;
    logic [2:0] step_w;
    logic       running_w;

    int n_cmp;
    int n_mis;

    // reference model: 0 idle, 1 run, 2 pause
    int         m_state, m_pos, m_dig, m_mode, m_step, m_sph;
    bit         m_req;
    logic [3:0] e_am;
    logic [7:0] e_out;
    logic       e_run;

    chase_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .STEP_DIV  (STEP_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .re       (re),
        .run      (run),
        .dir      (dir),
        .step_req (step_req),
        .clear    (clear),
        .mode     (mode),
        .am       (am_w),
        .out      (out_w),
        .step     (step_w),
        .running  (running_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_pat(int md, int dg, int st);
        logic [7:0] p;
        int k;
        k = (st + ((md == 1) ? dg : 0)) % 7;
        for (int i = 0; i < 8; i++) begin
            if (md == 3 || i == 0) p[i] = 1'b1;
            else if (i == 7 - k)   p[i] = (md == 2);
            else                   p[i] = (md != 2);
        end
        return p;
    endfunction

    function automatic logic [3:0] exp_am(int st, int pos, int dg);
        if (st == 0 || pos < BLANK_CYC) return 4'b1111;
        case (dg)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_dig = 0; m_mode = 0; m_step = 0; m_sph = 0;
        m_req = 0; e_am = 4'hF; e_out = 8'hFF; e_run = 1'b0;
    endtask

    task automatic model_step();
        bit rise, stick, slot_end;
        int ns;
        rise  = step_req && !m_req;
        e_run = (m_state == 1);
        stick = (m_state == 1) && (m_sph == STEP_DIV - 1);
        if (m_state == 0) begin
            ns = run ? 1 : 0;
            m_pos = 0;
            m_mode = mode;
        end else begin
            ns = run ? 1 : 2;
            slot_end = (m_pos == SCAN_DIV - 1);
            m_pos = slot_end ? 0 : m_pos + 1;
            if (slot_end) begin
                m_dig = (m_dig + 1) % 4;
                m_mode = mode;
            end
        end
        if (clear) begin
            m_step = 0;
            m_sph = 0;
        end else begin
            if (m_state == 1) m_sph = stick ? 0 : m_sph + 1;
            if (stick || (m_state == 2 && rise))
                m_step = dir ? (m_step + 6) % 7 : (m_step + 1) % 7;
        end
        m_req = step_req;
        m_state = ns;
        e_am = exp_am(m_state, m_pos, m_dig);
        if (m_state == 0)       e_out = 8'hFF;
        else if (e_am != 4'hF)  e_out = exp_pat(m_mode, m_dig, m_step);
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("am", {4'h0, am_w}, {4'h0, e_am});
        chk("out", out_w, e_out);
        chk("step", {5'd0, step_w}, 8'(m_step));
        chk("running", {7'd0, running_w}, {7'd0, e_run});
    endtask

    task automatic cycle();
        @(posedge clk);
        if (re) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        n_cmp = 0; n_mis = 0;
        re = 1'b1; run = 1'b0; dir = 1'b0; step_req = 1'b0; clear = 1'b0; mode = 2'd0;
        model_reset();

        // power-on reset
        #1 re = 1'b0;
        #1 check_all();
        cycles(3);
        @(negedge clk) re = 1'b1;
        cycles(4);

        // run, mode 0, increment through a full chase
        run = 1'b1;
        cycles(7 * STEP_DIV + 20);

        // decrement direction
        dir = 1'b1;
        cycles(2 * STEP_DIV + 10);

        // pause, two held step requests
        run = 1'b0; dir = 1'b0;
        cycles(5);
        for (int r = 0; r < 2; r++) begin
            step_req = 1'b1; cycles(10);
            step_req = 1'b0; cycles(5);
        end

        // pause at step 2 in rotate mode across all digits
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step_req = 1'b1; cycle();
            step_req = 1'b0; cycle();
        end
        chk("pause_step2", {5'd0, step_w}, 8'd2);
        mode = 2'd1; cycles(5 * SCAN_DIV);
        mode = 2'd2; cycles(5 * SCAN_DIV);

        // mode change in the middle of a lit slot
        found = 0;
        for (int i = 0; i < 4 * SCAN_DIV && !found; i++) begin
            if (m_pos == SCAN_DIV / 2 + 1) found = 1;
            else cycle();
        end
        chk("mid_slot_reach", {7'd0, found}, 8'd1);
        mode = 2'd0; cycle();
        chk("mid_slot_hold", out_w, exp_pat(2, m_dig, m_step));
        cycles(2 * SCAN_DIV);
        mode = 2'd3; cycles(2 * SCAN_DIV);
        mode = 2'd0;

        // clear coincident with a step tick at step 5
        run = 1'b1;
        clear = 1'b1; cycle(); clear = 1'b0;
        found = 0;
        for (int i = 0; i < 8 * STEP_DIV && !found; i++) begin
            if (m_state == 1 && m_step == 5 && m_sph == STEP_DIV - 1) found = 1;
            else cycle();
        end
        chk("clr_tick_reach", {7'd0, found}, 8'd1);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clr_tick_step", {5'd0, step_w}, 8'd0);
        cycles(STEP_DIV + 5);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 2)  run = ~run;
            if ($urandom_range(0, 99) < 2)  dir = ~dir;
            if ($urandom_range(0, 99) < 15) step_req = ~step_req;
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 3)  mode = 2'($urandom_range(0, 3));
            cycle();
        end
        clear = 1'b0;

        // asynchronous reset in the middle of a lit slot
        run = 1'b1; step_req = 1'b0;
        found = 0;
        for (int i = 0; i < 4 * SCAN_DIV && !found; i++) begin
            if (m_state != 0 && m_pos == SCAN_DIV - 2) found = 1;
            else cycle();
        end
        chk("async_reach", {7'd0, found}, 8'd1);
        #2 re = 1'b0;
        #1 model_reset();
        chk("async_am", {4'h0, am_w}, 8'h0F);
        chk("async_out", out_w, 8'hFF);
        chk("async_step", {5'd0, step_w}, 8'd0);
        chk("async_running", {7'd0, running_w}, 8'd0);
        run = 1'b0;
        cycles(3);
        @(negedge clk) re = 1'b1;
        cycles(6);
        run = 1'b1;
        cycles(3 * SCAN_DIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/chase_scan_ctrl.md
CHASE_SCAN_CTRL -- requirements
Module: chase_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (>= BLANK_CYC+2).
REQ-002 Parameter STEP_DIV, default 12500000, clk cycles per chase step in RUN.
REQ-003 Parameter BLANK_CYC, default 500, cycles all digits are off at each digit change.
REQ-004 clk  in  1  single system clock; all state changes on posedge clk.
REQ-005 re  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  level; 1 = advance the chase automatically, 0 = freeze the step.
REQ-007 dir  in  1  0 = step increments, 1 = step decrements.
REQ-008 step_req  in  1  single-step request, honoured in PAUSE only, rising-edge detected.
REQ-009 clear  in  1  synchronous; step := 0, step divider := 0.
REQ-010 mode  in  2  pattern set select.
REQ-011 am  out  4  digit enables, active-low, one-hot-low or 4'b1111.
REQ-012 out  out  8  segment drive, active-low (0 = lit).
REQ-013 step  out  3  current chase step, 0..6.
REQ-014 running  out  1  1 while the FSM is in RUN.

Function
REQ-015 FSM states are IDLE, RUN and PAUSE; IDLE->RUN on run=1; RUN->PAUSE on run=0; PAUSE->RUN on run=1; there is no return to IDLE except by reset.
REQ-016 In IDLE, am=4'b1111, out=8'hFF, and the scan and step counters are held at 0.
REQ-017 In RUN and PAUSE, the scan divider counts 0..SCAN_DIV-1 and wraps; the wrap cycle is scan_tick; digit index d advances 0->1->2->3->0 on scan_tick.
REQ-018 For BLANK_CYC cycles after each scan_tick, am=4'b1111; afterwards am = d0:1110, d1:1101, d2:1011, d3:0111.
REQ-019 out is registered and updates on the same edge on which am leaves 1111, so no segment is lit on the wrong digit.
REQ-020 mode is sampled only at scan_tick; a change in mid-slot takes effect from the next digit slot.
REQ-021 Segment index k = (step + offset) mod 7; offset = 0 in modes 0 and 2, offset = d in mode 1; k=0 maps to out[7] and k=6 to out[1]; out[0] is always 1.
REQ-022 Mode 0/1: out = all 1s except out[7-k]=0; mode 2: out = all 0s except out[7-k]=1 (out[0]=1); mode 3: out=8'hFF.
REQ-023 Step divider counts only in RUN; at wrap (step_tick), step becomes step+1 (6->0) if dir=0, or step-1 (0->6) if dir=1.
REQ-024 In PAUSE, each rising edge of step_req applies one dir-controlled step on the following edge; a held level counts once; edges in RUN/IDLE are ignored.
REQ-025 A step_tick in the same cycle that run falls is still applied (state is RUN that cycle).
REQ-026 clear has priority over step_tick and step_req in the same cycle; clear affects neither the scan divider nor d.
REQ-027 Scanning continues unchanged in PAUSE; only step is frozen.
REQ-028 running is asserted in the cycle after the state register enters RUN.

Reset
REQ-029 On re=0, asynchronously: state=IDLE, am=4'b1111, out=8'hFF, step=0, d=0, all dividers=0, running=0, step_req edge register=0.
REQ-030 Reset asserted mid-slot or mid-blank returns all outputs to their REQ-029 values without waiting for a clock edge.

Structure
REQ-031 The shared package holds the FSM state enum, the digit-enable constants (1110/1101/1011/0111/1111), and the mode encodings.
REQ-032 Pattern generation is a single combinational sub-module, chase_pattern_rom (inputs mode, d, step; output 8-bit pattern); the divider, FSM and blanking logic stay in chase_scan_ctrl.

Verification (SCAN_DIV=8, STEP_DIV=64, BLANK_CYC=2)
REQ-033 Reset then run=1, mode=0 -> am cycles 1111(2) 1110(6) 1111(2) 1101(6)...; out=8'b01111111 while step=0.
REQ-034 RUN with dir=0 for 7*64 cycles -> step sequence 1..6,0; with dir=1 from 0 -> 6 at the first step_tick.
REQ-035 run=0, then step_req held high 10 cycles, twice -> step advances exactly 2; am keeps scanning.
REQ-036 mode=1, step=2 -> d0 out=8'b11011111, d1 8'b11101111, d2 8'b11110111, d3 8'b11111011.
REQ-037 clear coincident with step_tick at step=5 -> step=0 on the next cycle; mode change in mid-slot -> out changes only after the next blank.
REQ-038 re=0 pulse mid-slot -> am=1111, out=FF, step=0 immediately; FSM is in IDLE until run=1.
